// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter: owner tags,
// response tag layout and default widths.
package dmem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_MEM_AW = 10;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_DMA  = 2'b10
  } owner_e;

  typedef struct packed {
    owner_e owner;
    logic   err;
  } tag_t;

  localparam tag_t TAG_NONE = '{owner: OWN_NONE, err: 1'b0};

  function automatic logic misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_arbiter_resp_tag_pipe.sv
// RD_LAT-deep shift register of {owner, err} tags; the oldest entry names
// the requester whose read data is on mem_rdata this cycle.
module resp_tag_pipe
  import dmem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_in,
  output tag_t tag_out
);

  // Out-of-range latencies are clamped so the pipe is always 1..4 deep
  localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                       ((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);

  tag_t pipe_q [LAT];
  tag_t pipe_d [LAT];

  // Next-state: new tag enters stage 0, older tags move one stage on
  always_comb begin
    pipe_d[0] = tag_in;
    for (int i = 1; i < LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Tag stages; reset drops every in-flight read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_q[i] <= TAG_NONE;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign tag_out = pipe_q[LAT-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU
// and a DMA/loader requester, with in-order read responses after RD_LAT.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int MEM_AW = DEF_MEM_AW,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  owner_e             last_owner_q, last_owner_d;
  logic               sel_we_s;
  logic [ADDR_W-1:0]  sel_addr_s;
  logic [DATA_W-1:0]  sel_wdata_s;
  logic               granted_s;
  logic               mis_s;
  tag_t               tag_in_s;
  tag_t               tag_out_s;
  logic               unused_addr_s;

  assign unused_addr_s = ^sel_addr_s[ADDR_W-1:MEM_AW+2];

  // Arbitration: on a tie the requester that did not win last time goes;
  // grants are held off while rst_n is low so every output reads 0
  always_comb begin
    cpu_gnt      = 1'b0;
    dma_gnt      = 1'b0;
    sel_we_s     = 1'b0;
    sel_addr_s   = '0;
    sel_wdata_s  = '0;
    last_owner_d = last_owner_q;
    if (rst_n && cpu_req && (!dma_req || (last_owner_q != OWN_CPU))) begin
      cpu_gnt      = 1'b1;
      sel_we_s     = cpu_we;
      sel_addr_s   = cpu_addr;
      sel_wdata_s  = cpu_wdata;
      last_owner_d = OWN_CPU;
    end else if (rst_n && dma_req) begin
      dma_gnt      = 1'b1;
      sel_we_s     = dma_we;
      sel_addr_s   = dma_addr;
      sel_wdata_s  = dma_wdata;
      last_owner_d = OWN_DMA;
    end else begin
      last_owner_d = last_owner_q;
    end
  end

  // Memory strobe and response tag; misaligned accesses never reach memory
  always_comb begin
    granted_s = cpu_gnt | dma_gnt;
    mis_s     = misaligned(sel_addr_s[1:0]);
    mem_en    = granted_s & ~mis_s;
    mem_we    = mem_en & sel_we_s;
    mem_addr  = sel_addr_s[MEM_AW+1:2];
    mem_wdata = sel_wdata_s;
    tag_in_s  = TAG_NONE;
    if (granted_s && !sel_we_s) begin
      tag_in_s.err = mis_s;
      if (cpu_gnt) begin
        tag_in_s.owner = OWN_CPU;
      end else begin
        tag_in_s.owner = OWN_DMA;
      end
    end else begin
      tag_in_s = TAG_NONE;
    end
  end

  resp_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in_s),
    .tag_out (tag_out_s)
  );

  // Response decode: read data is forced to 0 unless it belongs to that owner
  always_comb begin
    cpu_rvalid = (tag_out_s.owner == OWN_CPU);
    dma_rvalid = (tag_out_s.owner == OWN_DMA);
    cpu_err    = cpu_rvalid & tag_out_s.err;
    dma_err    = dma_rvalid & tag_out_s.err;
    cpu_rdata  = '0;
    dma_rdata  = '0;
    if (cpu_rvalid && !tag_out_s.err) begin
      cpu_rdata = mem_rdata;
    end else if (dma_rvalid && !tag_out_s.err) begin
      dma_rdata = mem_rdata;
    end else begin
      cpu_rdata = '0;
      dma_rdata = '0;
    end
  end

  // Round-robin pointer; DMA after reset so the CPU wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_q <= OWN_DMA;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter (RD_LAT = 2): directed scenarios plus
// a randomized run against a behavioural model of arbitration and memory.
module tb_dmem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MAW = 10;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata;
  logic          cpu_gnt, cpu_rvalid, cpu_err, dma_gnt, dma_rvalid, dma_err;
  logic [DW-1:0] cpu_rdata, dma_rdata;
  logic          mem_en, mem_we;
  logic [MAW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_AW(MAW), .RD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_err(dma_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Single-port memory with a 2-cycle read; junk on mem_rdata when idle
  logic [DW-1:0]  mem [0:1023];
  logic           pre_we = 1'b0;
  logic [MAW-1:0] pre_addr = '0;
  logic [DW-1:0]  pre_data = '0;
  logic           fill_req = 1'b0;
  logic [31:0]    fill_seed = 32'h0;
  logic [1:0]     rv_pipe = 2'b00;
  logic [DW-1:0]  rd_pipe0 = '0, rd_pipe1 = '0;

  function automatic logic [31:0] fill_fn(input int i, input logic [31:0] seed);
    return seed ^ (32'(i) * 32'h9E37_79B9);
  endfunction

  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < 1024; i++) mem[i] <= fill_fn(i, fill_seed);
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    rv_pipe  <= {rv_pipe[0], mem_en & ~mem_we};
    rd_pipe0 <= mem[mem_addr];
    rd_pipe1 <= rd_pipe0;
  end

  assign mem_rdata = rv_pipe[1] ? rd_pipe1 : 32'hA5A5_5A5A;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic idle(input int n);
    clear_reqs();
    repeat (n) cyc();
  endtask

  task automatic preload(input logic [MAW-1:0] a, input logic [DW-1:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    cyc();
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0;  cpu_wdata = 32'h1111_2222;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h4;  dma_wdata = 32'h3333_4444;
    repeat (2) cyc();
    #2;
    vectors++;
    if ({cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err, dma_gnt, dma_rvalid, dma_rdata, dma_err,
         mem_en, mem_we, mem_addr, mem_wdata} !== 114'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got gnt=%b%b en=%b we=%b addr=%0h wdata=%h rv=%b%b, expected all 0",
               cpu_gnt, dma_gnt, mem_en, mem_we, mem_addr, mem_wdata, cpu_rvalid, dma_rvalid);
    end
    cyc();
    rst_n = 1'b1;
    #2;
    vectors++;
    if ({cpu_gnt, dma_gnt} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_first_tie: got cpu/dma gnt=%b%b expected 10", cpu_gnt, dma_gnt);
    end
    idle(4);
  endtask

  task automatic test_cpu_read();
    preload(10'd4, 32'h1234_5678);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    #2;
    vectors++;
    if ({cpu_gnt, dma_gnt, mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 1'b1, 1'b0, 10'd4}) begin
      miscompares++;
      $display("FAIL cpu_read_grant: got gnt=%b%b en=%b we=%b addr=%0d expected 10 1 0 4",
               cpu_gnt, dma_gnt, mem_en, mem_we, mem_addr);
    end
    cyc();
    clear_reqs();
    #2;
    vectors++;
    if ({cpu_rvalid, dma_rvalid} !== 2'b00) begin
      miscompares++;
      $display("FAIL cpu_read_early: got rvalid=%b%b expected 00", cpu_rvalid, dma_rvalid);
    end
    cyc();
    #2;
    vectors++;
    if ({cpu_rvalid, cpu_err, cpu_rdata, dma_rvalid} !== {1'b1, 1'b0, 32'h1234_5678, 1'b0}) begin
      miscompares++;
      $display("FAIL cpu_read_resp: got rv=%b err=%b rdata=%h dma_rv=%b expected 1 0 12345678 0",
               cpu_rvalid, cpu_err, cpu_rdata, dma_rvalid);
    end
    idle(3);
  endtask

  task automatic test_dma_write();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h20; dma_wdata = 32'hDEAD_BEEF;
    #2;
    vectors++;
    if ({dma_gnt, cpu_gnt, mem_en, mem_we, mem_addr, mem_wdata} !==
        {1'b1, 1'b0, 1'b1, 1'b1, 10'd8, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("FAIL dma_write_drive: got gnt=%b%b en=%b we=%b addr=%0d wdata=%h expected 10 1 1 8 deadbeef",
               dma_gnt, cpu_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      clear_reqs();
      #2;
      vectors++;
      if ({cpu_rvalid, dma_rvalid} !== 2'b00) begin
        miscompares++;
        $display("FAIL dma_write_noresp: got rvalid=%b%b expected 00", cpu_rvalid, dma_rvalid);
      end
    end
    cyc();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
    cyc();
    clear_reqs();
    cyc();
    #2;
    vectors++;
    if ({cpu_rvalid, cpu_err, cpu_rdata} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("FAIL dma_write_readback: got rv=%b err=%b rdata=%h expected 1 0 deadbeef",
               cpu_rvalid, cpu_err, cpu_rdata);
    end
    idle(3);
  endtask

  task automatic test_alternate();
    logic [DW-1:0] exp_d;
    int ci, di, g;
    preload(10'd16, 32'hC0DE_0000);
    preload(10'd17, 32'hC0DE_0001);
    preload(10'd32, 32'hD0DE_0000);
    preload(10'd33, 32'hD0DE_0001);
    // A lone DMA write leaves the pointer on DMA so the CPU leads the tie
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h100; dma_wdata = 32'h0;
    #2;
    vectors++;
    if (dma_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL alt_prime: got dma_gnt=%b expected 1", dma_gnt);
    end
    ci = 0; di = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (k < 4) begin
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40 + 32'(4 * ci);
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h80 + 32'(4 * di);
      end else begin
        clear_reqs();
      end
      #2;
      if (k < 4) begin
        vectors++;
        if ({cpu_gnt, dma_gnt} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
          miscompares++;
          $display("FAIL alt_grant%0d: got cpu/dma gnt=%b%b expected %s", k, cpu_gnt, dma_gnt,
                   (k % 2 == 0) ? "10" : "01");
        end
        if (k % 2 == 0) ci++; else di++;
      end
      if (k >= 2) begin
        g = k - 2;
        exp_d = ((g % 2 == 0) ? 32'hC0DE_0000 : 32'hD0DE_0000) + 32'(g / 2);
        vectors++;
        if ({cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata} !==
            ((g % 2 == 0) ? {1'b1, 1'b0, exp_d, 32'h0} : {1'b0, 1'b1, 32'h0, exp_d})) begin
          miscompares++;
          $display("FAIL alt_resp%0d: got rv=%b%b cpu_rdata=%h dma_rdata=%h expected owner %s data %h",
                   g, cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata, (g % 2 == 0) ? "cpu" : "dma", exp_d);
        end
      end else begin
        vectors++;
        if ({cpu_rvalid, dma_rvalid} !== 2'b00) begin
          miscompares++;
          $display("FAIL alt_early%0d: got rvalid=%b%b expected 00", k, cpu_rvalid, dma_rvalid);
        end
      end
    end
    idle(3);
  endtask

  task automatic test_misaligned();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h13;
    #2;
    vectors++;
    if ({cpu_gnt, mem_en, mem_we} !== 3'b100) begin
      miscompares++;
      $display("FAIL mis_read_grant: got gnt=%b en=%b we=%b expected 1 0 0", cpu_gnt, mem_en, mem_we);
    end
    cyc();
    clear_reqs();
    cyc();
    #2;
    vectors++;
    if ({cpu_rvalid, cpu_err, cpu_rdata, dma_rvalid} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL mis_read_resp: got rv=%b err=%b rdata=%h dma_rv=%b expected 1 1 0 0",
               cpu_rvalid, cpu_err, cpu_rdata, dma_rvalid);
    end
    cyc();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h22; cpu_wdata = 32'h1111_1111;
    #2;
    vectors++;
    if ({cpu_gnt, mem_en, mem_we} !== 3'b100) begin
      miscompares++;
      $display("FAIL mis_write_drop: got gnt=%b en=%b we=%b expected 1 0 0", cpu_gnt, mem_en, mem_we);
    end
    cyc();
    cpu_we = 1'b0; cpu_addr = 32'h20; cpu_wdata = 32'h0;
    cyc();
    clear_reqs();
    #2;
    vectors++;
    if (cpu_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL mis_write_noresp: got cpu_rvalid=%b expected 0", cpu_rvalid);
    end
    cyc();
    #2;
    vectors++;
    if ({cpu_rvalid, cpu_err, cpu_rdata} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("FAIL mis_write_intact: got rv=%b err=%b rdata=%h expected 1 0 deadbeef",
               cpu_rvalid, cpu_err, cpu_rdata);
    end
    idle(3);
  endtask

  task automatic test_reset_midflight();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    #2;
    vectors++;
    if (cpu_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_grant: got cpu_gnt=%b expected 1", cpu_gnt);
    end
    cyc();
    clear_reqs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      #2;
      vectors++;
      if ({cpu_rvalid, dma_rvalid} !== 2'b00) begin
        miscompares++;
        $display("FAIL midrst_noresp%0d: got rvalid=%b%b expected 00", i, cpu_rvalid, dma_rvalid);
      end
    end
    cyc();
    cpu_req = 1'b1; cpu_addr = 32'h0;
    dma_req = 1'b1; dma_addr = 32'h4;
    #2;
    vectors++;
    if ({cpu_gnt, dma_gnt} !== 2'b10) begin
      miscompares++;
      $display("FAIL midrst_pointer: got cpu/dma gnt=%b%b expected 10", cpu_gnt, dma_gnt);
    end
    idle(4);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 1) == 0) a[11:2] = 10'($urandom_range(0, 15));
    if ($urandom_range(0, 9) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  task automatic test_random();
    logic [DW-1:0] ref_mem [0:1023];
    logic [3:0]    sv_c, sv_d, s_err;
    logic [DW-1:0] s_data [4];
    int            ref_last;       // 1 = CPU won last, 2 = DMA won last
    logic          ec, ed, c_done, d_done, w_we, mis;
    logic [31:0]   w_addr, w_data;
    logic [DW-1:0] e_cd, e_dd;
    int            s, t;

    cyc();
    fill_seed = $urandom;
    fill_req = 1'b1;
    cyc();
    fill_req = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = fill_fn(i, fill_seed);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    ref_last = 2;
    sv_c = 4'h0; sv_d = 4'h0; s_err = 4'h0;
    for (int i = 0; i < 4; i++) s_data[i] = '0;
    c_done = 1'b0; d_done = 1'b0;

    for (int n = 0; n < 400; n++) begin
      cyc();
      if (c_done) cpu_req = 1'b0;
      if (d_done) dma_req = 1'b0;
      if (!cpu_req && n < 390 && $urandom_range(0, 99) < 60) begin
        cpu_req = 1'b1; cpu_we = ($urandom_range(0, 2) == 0);
        cpu_addr = rand_addr(); cpu_wdata = $urandom;
      end
      if (!dma_req && n < 390 && $urandom_range(0, 99) < 60) begin
        dma_req = 1'b1; dma_we = ($urandom_range(0, 2) == 0);
        dma_addr = rand_addr(); dma_wdata = $urandom;
      end
      #2;

      s = n % 4;
      e_cd = (sv_c[s] && !s_err[s]) ? s_data[s] : 32'h0;
      e_dd = (sv_d[s] && !s_err[s]) ? s_data[s] : 32'h0;
      vectors++;
      if ({cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata, cpu_rvalid & cpu_err, dma_rvalid & dma_err} !==
          {sv_c[s], sv_d[s], e_cd, e_dd, sv_c[s] & s_err[s], sv_d[s] & s_err[s]}) begin
        miscompares++;
        $display("FAIL rand_resp@%0d: got rv=%b%b err=%b%b cpu=%h dma=%h expected rv=%b%b err=%b data=%h",
                 n, cpu_rvalid, dma_rvalid, cpu_err, dma_err, cpu_rdata, dma_rdata,
                 sv_c[s], sv_d[s], s_err[s], s_data[s]);
      end
      sv_c[s] = 1'b0; sv_d[s] = 1'b0; s_err[s] = 1'b0;

      ec = cpu_req && (!dma_req || ref_last != 1);
      ed = dma_req && !ec;
      vectors++;
      if ({cpu_gnt, dma_gnt} !== {ec, ed}) begin
        miscompares++;
        $display("FAIL rand_grant@%0d: got cpu/dma gnt=%b%b expected %b%b", n, cpu_gnt, dma_gnt, ec, ed);
      end

      if (ec || ed) begin
        w_we   = ec ? cpu_we : dma_we;
        w_addr = ec ? cpu_addr : dma_addr;
        w_data = ec ? cpu_wdata : dma_wdata;
        mis    = (w_addr[1:0] != 2'b00);
        vectors++;
        if (mem_en !== !mis) begin
          miscompares++;
          $display("FAIL rand_en@%0d: got mem_en=%b expected %b", n, mem_en, !mis);
        end
        if (!mis) begin
          vectors++;
          if ({mem_we, mem_addr} !== {w_we, w_addr[11:2]} || (w_we && mem_wdata !== w_data)) begin
            miscompares++;
            $display("FAIL rand_drive@%0d: got we=%b addr=%0d wdata=%h expected we=%b addr=%0d wdata=%h",
                     n, mem_we, mem_addr, mem_wdata, w_we, w_addr[11:2], w_data);
          end
        end
        if (!w_we) begin
          t = (n + LAT) % 4;
          sv_c[t] = ec; sv_d[t] = ed; s_err[t] = mis;
          s_data[t] = mis ? 32'h0 : ref_mem[w_addr[11:2]];
        end else if (!mis) begin
          ref_mem[w_addr[11:2]] = w_data;
        end
        ref_last = ec ? 1 : 2;
      end else begin
        vectors++;
        if ({mem_en, mem_we} !== 2'b00) begin
          miscompares++;
          $display("FAIL rand_idle@%0d: got en=%b we=%b expected 00", n, mem_en, mem_we);
        end
      end
      c_done = ec;
      d_done = ed;
    end
    idle(3);
  endtask

  initial begin
    rst_n = 1'b0;
    clear_reqs();
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_alternate();
    test_misaligned();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
